// File: rtl/z80_bus_responder.sv
// z80_bus_responder: tv80s bus slave with wait-state insertion, single-strobe RAM/IO backside and registered read data.
//   clk, reset             : rising-edge clock, synchronous active-high reset
//   A, dout, *_n           : CPU address, write data and active-low control strobes
//   di, wait_n             : registered read data and wait request back to the CPU
//   mem_* / io_*           : one-clock read/write strobes, address and write data; *_rdata valid one clock after *_re
module z80_bus_responder #(
  parameter int unsigned MEM_WAIT   = 0,
  parameter int unsigned M1_WAIT    = 0,
  parameter int unsigned IO_WAIT    = 1,
  parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic        io_re,
  output logic        io_we,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_CAPTURE, S_HOLD} state_t;
  typedef enum logic [2:0] {K_NONE, K_MRD, K_MWR, K_IRD, K_IWR, K_INTA} kind_t;
  state_t     state, state_n;
  kind_t      kind, kind_n, det;
  logic [4:0] cnt, cnt_n, det_cnt;
  logic       released, go;
  always_comb begin
    det = !mreq_n && rfsh_n && !rd_n ? K_MRD :
          !mreq_n && rfsh_n && !wr_n ? K_MWR :
          !iorq_n && !m1_n           ? K_INTA :
          !iorq_n && !rd_n           ? K_IRD :
          !iorq_n && !wr_n           ? K_IWR : K_NONE;
    det_cnt = det == K_MRD && !m1_n        ? 5'(MEM_WAIT + M1_WAIT) :
              det == K_MRD || det == K_MWR ? 5'(MEM_WAIT) : 5'(IO_WAIT);
    released = mreq_n && iorq_n;
    state_n = state;
    kind_n = kind;
    cnt_n = cnt;
    case (state)
      S_IDLE:
        if (det != K_NONE) begin
          kind_n = det;
          cnt_n = det_cnt;
          state_n = det_cnt == 5'd0 ? S_ACCESS : S_WAIT;
        end
      S_WAIT: begin
        if (released) state_n = S_IDLE;
        else if (cnt == 5'd1) state_n = S_ACCESS;
        else cnt_n = cnt - 5'd1;
      end
      S_ACCESS:  state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_HOLD;
      S_HOLD:    state_n = released ? S_IDLE : S_HOLD;
      default:   state_n = S_IDLE;
    endcase
    go = state_n == S_ACCESS;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      kind <= K_NONE;
      cnt <= 5'd0;
    end else begin
      state <= state_n;
      kind <= kind_n;
      cnt <= cnt_n;
    end
  end
  // Strobes and addresses are registered on entry to ACCESS so they are valid for exactly that clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      di <= 8'hFF;
      wait_n <= 1'b1;
      mem_addr <= 16'h0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      mem_wdata <= 8'h0;
      io_addr <= 8'h0;
      io_re <= 1'b0;
      io_we <= 1'b0;
      io_wdata <= 8'h0;
    end else begin
      wait_n <= state_n != S_WAIT;
      mem_re <= go && kind_n == K_MRD;
      mem_we <= go && kind_n == K_MWR;
      io_re <= go && kind_n == K_IRD;
      io_we <= go && kind_n == K_IWR;
      if (go && (kind_n == K_MRD || kind_n == K_MWR)) mem_addr <= A;
      if (go && kind_n == K_MWR) mem_wdata <= dout;
      if (go && (kind_n == K_IRD || kind_n == K_IWR)) io_addr <= A[7:0];
      if (go && kind_n == K_IWR) io_wdata <= dout;
      if (state == S_CAPTURE)
        di <= kind == K_MRD  ? mem_rdata :
              kind == K_IRD  ? io_rdata :
              kind == K_INTA ? INT_VECTOR : di;
    end
  end
endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder: scoreboard bench driving two differently parameterised responders with directed bus cycles.
module tb_z80_bus_responder;
  localparam int MRD = 1, MWR = 2, IRD = 3, IWR = 4, INTA = 5, REF = 6, TEND = 7;
  typedef struct {
    int          tag;
    logic [15:0] addr;
    logic [7:0]  data;
    int          waits;
  } ev_t;
  logic        clk = 1'b0;
  logic        rst [2];
  logic [15:0] a [2];
  logic [7:0]  dout [2];
  logic        m1_n [2], mreq_n [2], iorq_n [2], rd_n [2], wr_n [2], rfsh_n [2];
  logic [7:0]  di [2];
  logic        wait_n [2];
  logic [15:0] mem_addr [2];
  logic        mem_re [2], mem_we [2], io_re [2], io_we [2];
  logic [7:0]  mem_wdata [2], mem_rdata [2], io_addr [2], io_wdata [2], io_rdata [2];
  logic [7:0]  ram [2][65536];
  logic        pre = 1'b0;
  ev_t         q0 [$], q1 [$];
  int          vectors = 0, miscompares = 0;
  int          wcnt [2];
  bit          was_active [2];
  always #5 clk = ~clk;
  z80_bus_responder #(.MEM_WAIT(0), .M1_WAIT(0), .IO_WAIT(1), .INT_VECTOR(8'hC7)) u0 (
    .clk(clk), .reset(rst[0]), .A(a[0]), .dout(dout[0]), .m1_n(m1_n[0]), .mreq_n(mreq_n[0]),
    .iorq_n(iorq_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]), .rfsh_n(rfsh_n[0]), .di(di[0]),
    .wait_n(wait_n[0]), .mem_addr(mem_addr[0]), .mem_re(mem_re[0]), .mem_we(mem_we[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .io_addr(io_addr[0]), .io_re(io_re[0]),
    .io_we(io_we[0]), .io_wdata(io_wdata[0]), .io_rdata(io_rdata[0]));
  z80_bus_responder #(.MEM_WAIT(2), .M1_WAIT(1), .IO_WAIT(1), .INT_VECTOR(8'hFF)) u1 (
    .clk(clk), .reset(rst[1]), .A(a[1]), .dout(dout[1]), .m1_n(m1_n[1]), .mreq_n(mreq_n[1]),
    .iorq_n(iorq_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]), .rfsh_n(rfsh_n[1]), .di(di[1]),
    .wait_n(wait_n[1]), .mem_addr(mem_addr[1]), .mem_re(mem_re[1]), .mem_we(mem_we[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .io_addr(io_addr[1]), .io_re(io_re[1]),
    .io_we(io_we[1]), .io_wdata(io_wdata[1]), .io_rdata(io_rdata[1]));
  always @(posedge clk) begin
    if (!pre) begin
      ram[0][16'h0003] <= 8'h81;
      ram[1][16'h82FA] <= 8'hFA;
      pre <= 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (mem_we[i]) ram[i][mem_addr[i]] <= mem_wdata[i];
      if (mem_re[i]) mem_rdata[i] <= ram[i][mem_addr[i]];
      if (io_re[i]) io_rdata[i] <= io_addr[i] ^ 8'h5A;
    end
  end
  function automatic void push(int i, int tag, logic [15:0] addr, logic [7:0] data, int waits);
    ev_t e;
    e = '{tag, addr, data, waits};
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction
  function automatic void score(int i, ev_t g, bit ok);
    ev_t e;
    vectors++;
    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
      miscompares++;
      $display("FAIL u%0d unexpected event: got tag=%0d addr=%h data=%h waits=%0d, none required", i, g.tag, g.addr, g.data, g.waits);
      return;
    end
    e = i == 0 ? q0.pop_front() : q1.pop_front();
    if (!ok || g.tag != e.tag || g.addr !== e.addr || g.data !== e.data || g.waits != e.waits) begin
      miscompares++;
      $display("FAIL u%0d event: got tag=%0d addr=%h data=%h waits=%0d single=%0b, required tag=%0d addr=%h data=%h waits=%0d",
               i, g.tag, g.addr, g.data, g.waits, ok, e.tag, e.addr, e.data, e.waits);
    end
  endfunction
  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endfunction
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit active;
      logic [3:0] s;
      active = !mreq_n[i] || !iorq_n[i];
      if (active && !wait_n[i]) wcnt[i]++;
      s = {mem_re[i], mem_we[i], io_re[i], io_we[i]};
      if (s != 4'b0)
        score(i, '{mem_re[i] ? MRD : mem_we[i] ? MWR : io_re[i] ? IRD : IWR,
                   (mem_re[i] || mem_we[i]) ? mem_addr[i] : {8'h00, io_addr[i]},
                   mem_we[i] ? mem_wdata[i] : io_we[i] ? io_wdata[i] : 8'h00, 0}, $countones(s) == 1);
      if (was_active[i] && !active) begin
        score(i, '{TEND, 16'h0, di[i], wcnt[i]}, 1'b1);
        wcnt[i] = 0;
      end
      was_active[i] = active;
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic idle_bus(int i);
    a[i] = 16'h0; dout[i] = 8'h0;
    m1_n[i] = 1; mreq_n[i] = 1; iorq_n[i] = 1; rd_n[i] = 1; wr_n[i] = 1; rfsh_n[i] = 1;
  endtask
  task automatic drive(int i, int kind, logic [15:0] addr, logic [7:0] d, bit m1);
    a[i] = addr; dout[i] = d; m1_n[i] = !m1;
    mreq_n[i] = !(kind == MRD || kind == MWR || kind == REF);
    iorq_n[i] = !(kind == IRD || kind == IWR || kind == INTA);
    rd_n[i] = !(kind == MRD || kind == IRD);
    wr_n[i] = !(kind == MWR || kind == IWR);
    rfsh_n[i] = kind != REF;
    if (kind == INTA) m1_n[i] = 1'b0;
  endtask
  task automatic cycle(int i, int kind, logic [15:0] addr, logic [7:0] d, bit m1, int waits, logic [7:0] exp_di);
    if (kind == MRD || kind == MWR) push(i, kind, addr, kind == MWR ? d : 8'h00, 0);
    if (kind == IRD || kind == IWR) push(i, kind, {8'h00, addr[7:0]}, kind == IWR ? d : 8'h00, 0);
    push(i, TEND, 16'h0, exp_di, waits);
    drive(i, kind, addr, d, m1);
    tick(8);
    idle_bus(i);
    tick(1);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      wcnt[i] = 0;
      was_active[i] = 1'b0;
      idle_bus(i);
    end
    tick(2);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d reset di", i), 32'(di[i]), 32'hFF);
      chk($sformatf("u%0d reset strobes", i),
          32'({wait_n[i], mem_re[i], mem_we[i], io_re[i], io_we[i], mem_addr[i], io_addr[i]}), {7'd0, 1'b1, 28'd0});
    end
    cycle(0, MRD, 16'h0003, 8'h00, 1'b1, 0, 8'h81);
    cycle(0, IWR, 16'h12A5, 8'h3C, 1'b0, 1, 8'h81);
    cycle(0, IRD, 16'h0034, 8'h00, 1'b0, 1, 8'h6E);
    cycle(0, REF, 16'h0002, 8'h00, 1'b0, 0, 8'h6E);
    cycle(0, INTA, 16'h0000, 8'h00, 1'b1, 1, 8'hC7);
    cycle(0, MWR, 16'h4000, 8'h55, 1'b0, 0, 8'hC7);
    cycle(0, MRD, 16'h4000, 8'h00, 1'b0, 0, 8'h55);
    cycle(1, MRD, 16'h82FA, 8'h00, 1'b1, 3, 8'hFA);
    cycle(1, MRD, 16'h82FA, 8'h00, 1'b0, 2, 8'hFA);
    push(1, TEND, 16'h0, 8'hFF, 1);
    drive(1, MWR, 16'h1234, 8'hAA, 1'b0);
    tick(1);
    rst[1] = 1'b1;
    tick(1);
    rst[1] = 1'b0;
    idle_bus(1);
    chk("u1 wait_n after reset", 32'(wait_n[1]), 32'h1);
    chk("u1 di after reset", 32'(di[1]), 32'hFF);
    tick(2);
    cycle(1, MRD, 16'h82FA, 8'h00, 1'b0, 2, 8'hFA);
    tick(3);
    while (q0.size() > 0) begin
      ev_t e = q0.pop_front();
      vectors++; miscompares++;
      $display("FAIL u0 missing event: got nothing, required tag=%0d addr=%h data=%h", e.tag, e.addr, e.data);
    end
    while (q1.size() > 0) begin
      ev_t e = q1.pop_front();
      vectors++; miscompares++;
      $display("FAIL u1 missing event: got nothing, required tag=%0d addr=%h data=%h", e.tag, e.addr, e.data);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/z80_bus_responder.md
Name: z80_bus_responder

Overview:
- Synchronous bus-slave for the tv80s CPU: decodes memory, I/O and interrupt-acknowledge cycles on the CPU pins and generates `wait_n`.
- Drives the CPU data input `di`.
- Issues exactly one strobe per bus cycle to a backside synchronous RAM port and an 8-bit I/O register port.
- Replaces the ad-hoc negedge memory/IO models in CPU benches and in the SoC top.

Parameters:
- MEM_WAIT, 0, wait clocks inserted on memory read/write cycles (0..15)
- M1_WAIT, 0, extra wait clocks added on opcode-fetch (m1_n=0) memory reads (0..15)
- IO_WAIT, 1, wait clocks inserted on I/O read/write cycles (0..15)
- INT_VECTOR, 8'hFF, byte driven on `di` during interrupt acknowledge

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- A  in  16  CPU address bus
- dout  in  8  CPU write data
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU control strobes, active-low
- di  out  8  registered read data to CPU
- wait_n  out  1  registered wait request to CPU, active-low
- mem_addr  out  16  backside RAM address
- mem_re  out  1  one-clock RAM read strobe
- mem_we  out  1  one-clock RAM write strobe
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, valid one clock after mem_re
- io_addr  out  8  I/O port address (A[7:0])
- io_re  out  1  one-clock I/O read strobe
- io_we  out  1  one-clock I/O write strobe
- io_wdata  out  8  I/O write data
- io_rdata  in  8  I/O read data, valid one clock after io_re

Behaviour:
- Reset: state IDLE, di=8'hFF, wait_n=1, all strobes 0, mem_addr=0, io_addr=0, wdata outputs=0. Reset mid-cycle aborts immediately with no strobe emitted.
- Cycle classification, sampled in IDLE, at most one cycle active:
  - MEM_RD: mreq_n=0, rd_n=0, rfsh_n=1
  - MEM_WR: mreq_n=0, wr_n=0, rfsh_n=1
  - IO_RD: iorq_n=0, rd_n=0, m1_n=1
  - IO_WR: iorq_n=0, wr_n=0, m1_n=1
  - INTA: iorq_n=0, m1_n=0
  - Refresh (mreq_n=0, rfsh_n=0): ignored; no strobe, wait_n stays 1.
- Wait count latched at detection:
  - MEM_WAIT+M1_WAIT if MEM_RD with m1_n=0
  - MEM_WAIT for other memory cycles
  - IO_WAIT for IO and INTA
  - Count width 5 bits.
- FSM IDLE -> WAIT -> ACCESS -> CAPTURE -> HOLD -> IDLE.
  - WAIT: entered the clock after detection only if count>0. wait_n=0 for exactly count clocks, then 1. With count=0, go directly IDLE->ACCESS.
  - ACCESS (1 clk): assert exactly one strobe.
    - Memory cycles: mem_re or mem_we, mem_addr=A.
    - I/O cycles: io_re or io_we, io_addr=A[7:0].
    - Writes: wdata=dout sampled this clock.
    - INTA: no strobe.
  - CAPTURE (1 clk):
    - Reads: di<=mem_rdata or io_rdata.
    - INTA: di<=INT_VECTOR.
    - Writes: di unchanged.
  - HOLD: stay until mreq_n=1 and iorq_n=1, then IDLE. di is held stable throughout HOLD and IDLE.
- Abort: if mreq_n=1 and iorq_n=1 during WAIT, go to IDLE, wait_n<=1, no strobe.
- Back-to-back: a new cycle asserted in the same clock that HOLD exits is detected on the next IDLE clock. No strobe merging.
- Strobes never overlap; mem_* and io_* never active in the same clock.

Test Plan:
- MEM_WAIT=0; opcode fetch A=16'h0003, mem_rdata=8'h81 -> one mem_re pulse with mem_addr=0003, wait_n never low, di=81 two clocks after detection, held until mreq_n rises.
- MEM_WAIT=2, M1_WAIT=1; M1 read at 82FA (rdata FA) -> wait_n low exactly 3 clocks, then mem_re once, di=FA. A non-M1 read of the same address gives 2 wait clocks.
- IO_WAIT=1; OUT to A=16'h12A5, dout=3C -> wait_n low 1 clock, io_we pulse with io_addr=A5 and io_wdata=3C, no mem_* activity.
- Refresh cycle (mreq_n=0, rfsh_n=0, A=0x0002), then INTA with INT_VECTOR=8'hC7 -> no strobes for refresh; INTA gives di=C7 after IO_WAIT clocks with no strobes.
- Reset asserted in WAIT of a memory write -> next clock wait_n=1, di=FF, no mem_we ever issued. A following read completes normally.
- Back-to-back MEM_WR 16'h4000<-55 then MEM_RD 16'h4000 with a RAM model -> exactly one mem_we then one mem_re, di=55.
